// File: rtl/nt_subckt_test_sequencer.sv
// Reset / LFSR-stimulus / MISR-compaction sequencer for one Nt-node subcircuit under test.
// Optional abort input is compiled in with `define NT_SEQ_ABORT_EN.
module nt_subckt_test_sequencer #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned RST_CYCLES  = 2,
    parameter logic [6:0]  SEED        = 7'h5A,
    parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic        I1470_clk,
    input  logic        I1477_rst,
    input  logic        start,
`ifdef NT_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic [6:0]  dut_in,
    output logic        dut_rst,
    input  logic        dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [2:0] {IDLE, RSTDUT, APPLY, DRAIN, CHECK} state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [6:0]  SEED_EFF = (SEED == 7'h00) ? 7'h01 : SEED;
    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] LAST_RST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LAST_DRN = (LATENCY == 0) ? 16'd0 : 16'(LATENCY - 1);

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [6:0]    lfsr_q;
    logic [15:0]   sig_q;
    logic [6:0]    dut_in_q;
    logic          dut_rst_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [LATENCY:0] vld_pipe_q;

    logic [6:0]    lfsr_d;
    logic [15:0]   sig_d;
    logic          start_ok;

    assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

    // vld_pipe_q[0] marks a vector on dut_in this cycle; tap LATENCY lines up with dut_out.
    always_comb begin
        sig_d = sig_q;
        if (vld_pipe_q[LATENCY])
            sig_d = {sig_q[14:0], 1'b0} ^ ({16{sig_q[15] ^ dut_out}} & 16'h1021);
    end

`ifdef NT_SEQ_ABORT_EN
    assign start_ok = start & ~abort;
`else
    assign start_ok = start;
`endif

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            lfsr_q     <= SEED_EFF;
            sig_q      <= 16'h0000;
            dut_in_q   <= 7'h00;
            dut_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            vld_pipe_q <= '0;
        end
`ifdef NT_SEQ_ABORT_EN
        else if (abort && state_q != IDLE) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            dut_in_q   <= 7'h00;
            dut_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            vld_pipe_q <= '0;
        end
`endif
        else begin
            done_q        <= 1'b0;
            sig_q         <= sig_d;
            vld_pipe_q[0] <= 1'b0;
            for (int i = 1; i <= int'(LATENCY); i++)
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            case (state_q)
                IDLE: begin
                    dut_rst_q <= 1'b0;
                    if (start_ok) begin
                        state_q   <= RSTDUT;
                        dut_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= 16'd0;
                        lfsr_q    <= SEED_EFF;
                        sig_q     <= 16'h0000;
                        pass_q    <= 1'b0;
                    end
                end
                RSTDUT: begin
                    if (cnt_q == LAST_RST) begin
                        state_q       <= APPLY;
                        dut_rst_q     <= 1'b0;
                        dut_in_q      <= lfsr_q;
                        lfsr_q        <= lfsr_d;
                        vld_pipe_q[0] <= 1'b1;
                        cnt_q         <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                APPLY: begin
                    if (cnt_q == LAST_VEC) begin
                        dut_in_q <= 7'h00;
                        cnt_q    <= 16'd0;
                        if (LATENCY == 0) begin
                            state_q <= CHECK;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_d == GOLDEN_SIG);
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        dut_in_q      <= lfsr_q;
                        lfsr_q        <= lfsr_d;
                        vld_pipe_q[0] <= 1'b1;
                        cnt_q         <= cnt_q + 16'd1;
                    end
                end
                DRAIN: begin
                    // The last capture lands on this edge, so compare the next-state signature.
                    if (cnt_q == LAST_DRN) begin
                        state_q <= CHECK;
                        done_q  <= 1'b1;
                        pass_q  <= (sig_d == GOLDEN_SIG);
                        cnt_q   <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in    = dut_in_q;
    assign dut_rst   = dut_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_nt_subckt_test_sequencer.sv
// Randomized bench for nt_subckt_test_sequencer: a run-timeline model predicts every output each cycle.
`timescale 1ns/1ps
module tb_nt_subckt_test_sequencer;
    localparam int N = 4, L = 2, R = 2;
    localparam logic [6:0]  SEED = 7'h5A;
    localparam logic [15:0] GOLD = 16'hF1EF;   // MISR of four captured ones
    localparam int RUN = R + N + L + 1;        // cycle offset of done from start

    logic clk = 0, rst = 1, start = 0, abort = 0, dut_out = 0;
    logic [6:0] dut_in;
    logic dut_rst, busy, done, pass;
    logic [15:0] signature;

    int cyc = 0, checks = 0, passed = 0;
    int mode = 0, flip_cyc = -1;
    bit model_on = 0;
    logic [6:0] pv [4] = '{7'h5A, 7'h35, 7'h6B, 7'h56};

    nt_subckt_test_sequencer #(.NUM_VECTORS(N), .LATENCY(L), .RST_CYCLES(R),
                               .SEED(SEED), .GOLDEN_SIG(GOLD)) dut (
        .I1470_clk(clk), .I1477_rst(rst), .start(start),
`ifdef NT_SEQ_ABORT_EN
        .abort(abort),
`endif
        .dut_in(dut_in), .dut_rst(dut_rst), .dut_out(dut_out), .busy(busy),
        .done(done), .pass(pass), .signature(signature));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] lfsr_at(int j);
        logic [6:0] s;
        s = (SEED == 7'h00) ? 7'h01 : SEED;
        for (int i = 0; i < j; i++) s = {s[5:0], s[6] ^ s[5]};
        return s;
    endfunction

    function automatic logic [15:0] misr(logic [15:0] s, logic b);
        return {s[14:0], 1'b0} ^ (((s[15] ^ b) != 1'b0) ? 16'h1021 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        #1;
        case (mode)
            0:       dut_out = 1'($urandom);
            1:       dut_out = 1'b1;
            2:       dut_out = (cyc == flip_cyc) ? 1'b0 : 1'b1;
            default: dut_out = 1'b0;
        endcase
    end

    // Model: a run is the start cycle T; every output follows from the offset k-T.
    int run_t = -1000;
    logic [15:0] sig_m = 16'h0;
    logic pass_m = 0, sp = 0, rp = 0, op = 0, ap = 0;

    always @(negedge clk) begin
        int k, relp, rel;
        bit bz, b;
        k = cyc;
        relp = k - 1 - run_t;
        bz = (relp >= 1 && relp <= RUN);
        if (rp) begin
            run_t = -1000; sig_m = 16'h0; pass_m = 0;
        end else if (ap && bz) begin
            run_t = -1000; pass_m = 0;
        end else begin
            if (bz && relp >= R + 1 + L && relp <= R + L + N) sig_m = misr(sig_m, op);
            if (bz && relp == RUN - 1) pass_m = (sig_m == GOLD);
            if (sp && !ap && !bz) begin
                run_t = k - 1; sig_m = 16'h0; pass_m = 0;
            end
        end
        rel = k - run_t;
        if (model_on) begin
            b = (rel >= 1 && rel <= RUN);
            chk("busy", busy, b);
            chk("dut_rst", dut_rst, rp || (b && rel <= R));
            chk("dut_in", dut_in, (b && rel >= R + 1 && rel <= R + N) ? lfsr_at(rel - R - 1) : 7'h00);
            chk("done", done, b && rel == RUN);
            chk("pass", pass, pass_m);
            chk("signature", signature, sig_m);
        end
        sp = start; rp = rst; op = dut_out; ap = abort;
    end

    task automatic wait_idle(output int dones);
        bit ok;
        dones = 0; ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (done) dones++;
            if (!busy) ok = 1;
        end
        if (!ok) begin
            checks++;
            $display("FAIL wait_idle_timeout cyc=%0d got=busy exp=idle", cyc);
        end
    endtask

    task automatic run(input int m, output int dones);
        mode = m; start = 1; tick(); start = 0;
        wait_idle(dones);
    endtask

    initial begin
        int dn, act, t0;
        rst = 1; repeat (2) tick(); model_on = 1; tick();
        chk("rst_busy", busy, 0); chk("rst_dut_rst", dut_rst, 1); chk("rst_done", done, 0);
        chk("rst_pass", pass, 0); chk("rst_sig", signature, 0); chk("rst_dut_in", dut_in, 0);
        rst = 0; repeat (6) tick();

        // Timing and vector pins, all-ones capture against the golden signature
        mode = 1; start = 1; t0 = cyc; tick(); start = 0;
        chk("t_rst1", dut_rst, 1); tick();
        chk("t_rst2", dut_rst, 1); tick();
        for (int i = 0; i < 4; i++) begin
            chk("t_vec", dut_in, pv[i]); chk("t_dut_rst_low", dut_rst, 0); tick();
        end
        chk("t_nodone7", done, 0); tick();
        chk("t_nodone8", done, 0); tick();
        chk("t_done_cycle", cyc - t0, RUN);
        chk("t_done", done, 1); chk("gold_pass", pass, 1); chk("gold_sig", signature, 16'hF1EF);
        tick();
        chk("t_done_pulse", done, 0); chk("gold_pass_held", pass, 1); chk("t_idle", busy, 0);
        repeat (3) tick();

        // One flipped capture bit must fail the compare
        flip_cyc = cyc + R + L + 2;
        run(2, dn);
        chk("flip_pass", pass, 0); chk("flip_dones", dn, 1);
        run(3, dn);
        chk("zero_sig", signature, 0); chk("zero_pass", pass, 0);

        // Start while busy is ignored
        mode = 0; start = 1; tick(); start = 0;
        repeat (R + 2) tick();
        start = 1; tick(); start = 0;
        wait_idle(dn);
        chk("busy_start_dones", dn, 1);
        repeat (2) tick();

        // Reset mid-run, then an uninterrupted run
        mode = 1; start = 1; tick(); start = 0;
        repeat (R + 2) tick();
        rst = 1; tick(); rst = 0;
        chk("mr_busy", busy, 0); chk("mr_dut_rst", dut_rst, 1); chk("mr_sig", signature, 0);
        chk("mr_dut_in", dut_in, 0); chk("mr_pass", pass, 0);
        tick();
        run(1, dn);
        chk("mr_rerun_sig", signature, 16'hF1EF); chk("mr_rerun_pass", pass, 1);

`ifdef NT_SEQ_ABORT_EN
        mode = 0; start = 1; tick(); start = 0;
        repeat (R + 2) tick();
        abort = 1; tick(); abort = 0;
        chk("ab_busy", busy, 0); chk("ab_done", done, 0); chk("ab_pass", pass, 0);
        chk("ab_dut_rst", dut_rst, 0);
        tick();
        abort = 1; start = 1; tick(); abort = 0; start = 0;
        chk("ab_start_idle", busy, 0);
        tick();
`endif

        // Randomized runs with stray starts and occasional reset or abort
        for (int r = 0; r < 25; r++) begin
            act = $urandom_range(0, 5);
            mode = 0;
            repeat ($urandom_range(0, 3)) tick();
            start = 1; tick(); start = 0;
            repeat ($urandom_range(0, RUN + 1)) begin
                start = ($urandom_range(0, 3) == 0);
                tick();
            end
            start = 0;
            if (act == 0) begin rst = 1; tick(); rst = 0; end
`ifdef NT_SEQ_ABORT_EN
            if (act == 1) begin abort = 1; tick(); abort = 0; end
`endif
            wait_idle(dn);
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
